uart_tx_baud: RTL and testbench

//   Serial UART transmitter with built-in baud-rate generator, used for node debug/telemetry output.
//   The host (e.g. the CAN node message buffer drain logic) presents a byte and pulses send while ready is high.
//   The block shifts the byte out as one 8N1 frame on tx: start bit, 8 data bits LSB first, 1 stop bit.

---
 rtl/uart_tx_baud.sv | 100 ++++++++++
 tb/tb_uart_tx_baud.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_baud.sv
// 8N1 UART transmitter with an internal baud-rate clock enable.
// A byte is taken on any sys_clk edge where send=1 and ready=1; tx falls on the next cycle.
module uart_tx_baud #(
  parameter int DIVISOR = 868,
  parameter int CNT_W   = 16
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic [7:0] uart_data,
  input  logic       send,
  output logic       ready,
  output logic       tx,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DIVISOR - 1);

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_end;
  logic [2:0]       next_idx;

  assign bit_end   = (baud_cnt == BIT_LAST);
  assign next_idx  = bit_idx + 3'd1;
  assign state_dbg = state;

  // tx and ready are loaded with the value of the state being entered, so both stay registered.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      ready    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (send && ready) begin
            shreg    <= uart_data;
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= START;
            tx       <= 1'b0;
            ready    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx       <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= next_idx;
              tx      <= shreg[next_idx];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= IDLE;
            ready    <= 1'b1;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_baud.sv
// Bench for uart_tx_baud: a fast instance (DIVISOR=4) and a real-rate one (DIVISOR=868),
// each tracked by a line-waveform model and a mid-bit sampling receiver.
`timescale 1ns/1ps
module tb_uart_tx_baud;
  localparam int D4 = 4;
  localparam int D8 = 868;

  // clock / reset
  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic       reset;
  logic [7:0] data4, data8;
  logic       send4, send8;
  logic       ready4, tx4, ready8, tx8;
  logic [1:0] st4, st8;

  uart_tx_baud #(.DIVISOR(D4), .CNT_W(16)) dut4 (
    .sys_clk(sys_clk), .reset(reset), .uart_data(data4), .send(send4),
    .ready(ready4), .tx(tx4), .state_dbg(st4));

  uart_tx_baud #(.DIVISOR(D8), .CNT_W(16)) dut8 (
    .sys_clk(sys_clk), .reset(reset), .uart_data(data8), .send(send8),
    .ready(ready8), .tx(tx8), .state_dbg(st8));

  int total = 0;
  int bad   = 0;
  bit run_model = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return d[b-1];
  endfunction

  // scoreboard: expected line samples and expected decoded bytes per instance
  logic       w4_q[$];
  logic       w8_q[$];
  logic [7:0] exp4_q[$];
  logic [7:0] exp8_q[$];
  int         busy4 = 0;
  int         busy8 = 0;

  always @(negedge sys_clk) begin
    if (run_model) begin
      logic rdy;
      rdy = (busy4 == 0);
      check("m4_tx", tx4, (w4_q.size() > 0) ? w4_q[0] : 1'b1);
      check("m4_ready", ready4, rdy);
      if (w4_q.size() > 0) void'(w4_q.pop_front());
      if (busy4 > 0) busy4--;
      if (reset) begin
        w4_q.delete(); exp4_q.delete(); busy4 = 0;
      end else if (rdy && send4) begin
        for (int b = 0; b < 10; b++)
          for (int c = 0; c < D4; c++) w4_q.push_back(frame_bit(data4, b));
        busy4 = 10 * D4;
        exp4_q.push_back(data4);
      end
    end
  end

  always @(negedge sys_clk) begin
    if (run_model) begin
      logic rdy;
      rdy = (busy8 == 0);
      check("m8_tx", tx8, (w8_q.size() > 0) ? w8_q[0] : 1'b1);
      check("m8_ready", ready8, rdy);
      if (w8_q.size() > 0) void'(w8_q.pop_front());
      if (busy8 > 0) busy8--;
      if (reset) begin
        w8_q.delete(); exp8_q.delete(); busy8 = 0;
      end else if (rdy && send8) begin
        for (int b = 0; b < 10; b++)
          for (int c = 0; c < D8; c++) w8_q.push_back(frame_bit(data8, b));
        busy8 = 10 * D8;
        exp8_q.push_back(data8);
      end
    end
  end

  // receivers: find the falling start edge, then sample each bit at its centre
  int         rpos4 = -1, rpos8 = -1;
  logic [7:0] rsh4, rsh8;

  always @(negedge sys_clk) begin
    if (!run_model || reset) rpos4 = -1;
    else begin
      if (rpos4 >= 0) rpos4++;
      else if (tx4 == 1'b0) rpos4 = 0;
      if (rpos4 >= 0) begin
        if (rpos4 == D4 / 2) check("rx4_start", tx4, 1'b0);
        if (rpos4 >= D4 + D4 / 2 && rpos4 < 9 * D4 && (rpos4 % D4) == D4 / 2)
          rsh4[rpos4 / D4 - 1] = tx4;
        if (rpos4 == 9 * D4 + D4 / 2) begin
          check("rx4_stop", tx4, 1'b1);
          check("rx4_pending", exp4_q.size() > 0, 1'b1);
          if (exp4_q.size() > 0) check("rx4_byte", rsh4, exp4_q.pop_front());
        end
        if (rpos4 == 10 * D4 - 1) rpos4 = -1;
      end
    end
  end

  always @(negedge sys_clk) begin
    if (!run_model || reset) rpos8 = -1;
    else begin
      if (rpos8 >= 0) rpos8++;
      else if (tx8 == 1'b0) rpos8 = 0;
      if (rpos8 >= 0) begin
        if (rpos8 == D8 / 2) check("rx8_start", tx8, 1'b0);
        if (rpos8 >= D8 + D8 / 2 && rpos8 < 9 * D8 && (rpos8 % D8) == D8 / 2)
          rsh8[rpos8 / D8 - 1] = tx8;
        if (rpos8 == 9 * D8 + D8 / 2) begin
          check("rx8_stop", tx8, 1'b1);
          check("rx8_pending", exp8_q.size() > 0, 1'b1);
          if (exp8_q.size() > 0) check("rx8_byte", rsh8, exp8_q.pop_front());
        end
        if (rpos8 == 10 * D8 - 1) rpos8 = -1;
      end
    end
  end

  // driver tasks: inputs change 2 ns after the rising edge
  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic send_pulse4(input logic [7:0] d);
    data4 = d;
    send4 = 1'b1;
    tick();
    send4 = 1'b0;
  endtask

  task automatic wait_ready4(input int budget, input string name);
    int n = 0;
    while (!ready4 && n < budget) begin
      tick();
      n++;
    end
    check(name, ready4, 1'b1);
  endtask

  // called on the first cycle after the accept edge
  task automatic frame_check4(input logic [9:0] frame, input string name);
    for (int m = 0; m < 10 * D4; m++) begin
      if ((m % D4) == D4 / 2) check($sformatf("%s_bit%0d", name, m / D4), tx4, frame[m / D4]);
      if (m == 0 || m == 10 * D4 - 1) check($sformatf("%s_busy%0d", name, m), ready4, 1'b0);
      tick();
    end
    check($sformatf("%s_ready_back", name), ready4, 1'b1);
  endtask

  typedef struct {
    logic [7:0] d;
    logic [9:0] frame;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    int lo;
    int run;
    logic cur;
    int runs[$];

    vecs[0] = '{8'h89, 10'b1_10001001_0};
    vecs[1] = '{8'h00, 10'b1_00000000_0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0};
    vecs[3] = '{8'h55, 10'b1_01010101_0};
    vecs[4] = '{8'hA3, 10'b1_10100011_0};
    vecs[5] = '{8'h3C, 10'b1_00111100_0};

    reset = 1'b1; send4 = 1'b0; send8 = 1'b0; data4 = 8'h00; data8 = 8'h00;
    repeat (3) tick();
    run_model = 1'b1;
    check("rst_state4", st4, 2'd0);
    check("rst_state8", st8, 2'd0);
    check("rst_tx4", tx4, 1'b1);
    check("rst_ready4", ready4, 1'b1);
    reset = 1'b0;

    // idle line after reset release
    for (int k = 0; k < 50; k++) begin
      tick();
      if ((k % 10) == 9) begin
        check("idle_tx", tx4, 1'b1);
        check("idle_ready", ready4, 1'b1);
      end
    end

    // table of single frames
    for (int i = 0; i < 5; i++) begin
      send_pulse4(vecs[i].d);
      frame_check4(vecs[i].frame, $sformatf("vec%0d", i));
      repeat (2) tick();
    end

    // back-to-back: send held across the first frame
    data4 = 8'h12;
    send4 = 1'b1;
    tick();
    data4 = 8'h0A;
    n = 0;
    while (!ready4 && n < 100) begin
      tick();
      n++;
    end
    check("b2b_busy_len", n, 10 * D4);
    check("b2b_gap_tx", tx4, 1'b1);
    tick();
    check("b2b_start", tx4, 1'b0);
    check("b2b_busy", ready4, 1'b0);
    send4 = 1'b0;
    wait_ready4(100, "b2b_timeout");
    repeat (3) tick();

    // request and data change while busy are ignored
    send_pulse4(8'h00);
    repeat (14) tick();
    data4 = 8'hFF;
    send4 = 1'b1;
    tick();
    send4 = 1'b0;
    wait_ready4(100, "busy_req_timeout");
    repeat (20) tick();
    check("no_extra_tx", tx4, 1'b1);
    check("no_extra_q", exp4_q.size(), 0);

    // reset during data bit 3
    send_pulse4(8'hC6);
    repeat (17) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_tx", tx4, 1'b1);
    check("rst_mid_ready", ready4, 1'b1);
    check("rst_mid_state", st4, 2'd0);
    send_pulse4(vecs[5].d);
    frame_check4(vecs[5].frame, "after_rst");

    // random traffic with occasional resets
    for (int k = 0; k < 1500; k++) begin
      reset = ($urandom_range(0, 399) == 0);
      send4 = ($urandom_range(0, 2) == 0);
      data4 = 8'($urandom_range(0, 255));
      tick();
    end
    reset = 1'b0;
    send4 = 1'b0;
    wait_ready4(100, "rand_timeout");
    repeat (3) tick();

    // full-rate frame on the DIVISOR=868 instance
    data8 = 8'h55;
    send8 = 1'b1;
    tick();
    send8 = 1'b0;
    lo = 0;
    cur = tx8;
    run = 0;
    while (!ready8 && lo < 9000) begin
      if (tx8 === cur) run++;
      else begin
        runs.push_back(run);
        cur = tx8;
        run = 1;
      end
      tick();
      lo++;
    end
    runs.push_back(run);
    check("f868_busy_len", lo, 10 * D8);
    check("f868_runs", runs.size(), 10);
    for (int i = 0; i < runs.size(); i++) check($sformatf("f868_run%0d", i), runs[i], D8);
    repeat (5) tick();

    check("end_q4", exp4_q.size(), 0);
    check("end_q8", exp8_q.size(), 0);
    check("end_rx4_idle", rpos4, -1);
    check("end_rx8_idle", rpos8, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
